// File: rtl/addr_data_arb_if.sv
// addr_data_arb_if: bundles the GPU write bus, the ADDQ update bus and the
// registered output bus of the address-register data arbiter.
// The master side drives requests and out_ready; the slave side (the arbiter)
// drives the readies and the registered output word.
interface addr_data_arb_if #(
  parameter int HALF_W = 16
);
  // GPU write source; gpu_din carries X in its upper half, Y in its lower half
  logic                  gpu_valid;
  logic                  gpu_ready;
  logic [2*HALF_W-1:0]   gpu_din;
  logic                  gpu_en_lo;
  logic                  gpu_en_hi;

  // ADDQ incrementer source, always writes both halves
  logic                  addq_valid;
  logic                  addq_ready;
  logic [HALF_W-1:0]     addq_x;
  logic [HALF_W-1:0]     addq_y;

  // Registered output stage
  logic                  out_valid;
  logic                  out_ready;
  logic [HALF_W-1:0]     data_x;
  logic [HALF_W-1:0]     data_y;
  logic                  mask_x;
  logic                  mask_y;
  logic                  out_src;

  modport master (
    output gpu_valid, gpu_din, gpu_en_lo, gpu_en_hi,
    input  gpu_ready,
    output addq_valid, addq_x, addq_y,
    input  addq_ready,
    input  out_valid, data_x, data_y, mask_x, mask_y, out_src,
    output out_ready
  );

  modport slave (
    input  gpu_valid, gpu_din, gpu_en_lo, gpu_en_hi,
    output gpu_ready,
    input  addq_valid, addq_x, addq_y,
    output addq_ready,
    output out_valid, data_x, data_y, mask_x, mask_y, out_src,
    input  out_ready
  );
endinterface

// File: rtl/addr_data_arb.sv
// addr_data_arb: arbitrates GPU writes and ADDQ updates onto the address
// register X/Y write path through a single registered output stage.
// Optional macro ADDR_DATA_ARB_STARVE_EN builds a bounded-starvation counter
// so that a pending GPU write wins after MAX_STARVE consecutive ADDQ grants;
// without it ADDQ has strict priority.
module addr_data_arb #(
  parameter int HALF_W     = 16,
  parameter int MAX_STARVE = 3
) (
  input  logic           clk,
  input  logic           resetl,
  addr_data_arb_if.slave bus
);

  // MAX_STARVE must fit the 4-bit counter and allow at least one ADDQ grant
  if (MAX_STARVE < 1 || MAX_STARVE > 15) begin : g_bad_max_starve
    $error("addr_data_arb: MAX_STARVE must be in 1..15");
  end

  logic              out_valid_reg;
  logic [HALF_W-1:0] data_x_reg;
  logic [HALF_W-1:0] data_y_reg;
  logic              mask_x_reg;
  logic              mask_y_reg;
  logic              out_src_reg;

  logic              load;
  logic              gpu_turn;
  logic              gpu_ready_int;
  logic              addq_ready_int;
  logic              gpu_xfer;
  logic              addq_xfer;

  // The GPU bus is numbered MSB-first: half 0 (X) occupies the numerically
  // upper bits, half 1 (Y) the lower bits.
  logic [HALF_W-1:0] gpu_half [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_gpu_half
    assign gpu_half[gi] = bus.gpu_din[(2-gi)*HALF_W-1 -: HALF_W];
  end

  // The output register can take a new word when empty or being drained
  assign load = !out_valid_reg || bus.out_ready;

`ifdef ADDR_DATA_ARB_STARVE_EN
  localparam logic [3:0] STARVE_LIM = 4'(MAX_STARVE);

  logic [3:0] starve_cnt_reg;
  logic [3:0] starve_cnt_next;

  // GPU wins a contested cycle once ADDQ has used up its allowance
  assign gpu_turn = (starve_cnt_reg >= STARVE_LIM);

  // Count ADDQ grants that overtook a waiting GPU; any GPU grant or an idle GPU restarts the count
  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (addq_xfer && bus.gpu_valid) begin
      if (starve_cnt_reg >= STARVE_LIM) begin
        starve_cnt_next = STARVE_LIM;
      end else begin
        starve_cnt_next = starve_cnt_reg + 4'd1;
      end
    end else if (gpu_xfer || !bus.gpu_valid) begin
      starve_cnt_next = 4'd0;
    end
  end

  // Starvation counter register
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      starve_cnt_reg <= 4'd0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
    end
  end
`else
  // Without the counter ADDQ always wins a contested cycle
  assign gpu_turn = 1'b0;
`endif

  // Grant: each ready depends only on the other source's valid, never its own,
  // so a source can present valid after seeing ready without a loop.
  always_comb begin
    addq_ready_int = 1'b0;
    gpu_ready_int  = 1'b0;
    if (load) begin
      addq_ready_int = !(bus.gpu_valid && gpu_turn);
      gpu_ready_int  = !bus.addq_valid || gpu_turn;
    end
  end

  assign addq_xfer = bus.addq_valid && addq_ready_int;
  assign gpu_xfer  = bus.gpu_valid && gpu_ready_int;

  // Output stage: capture the winner, hold while stalled, empty when drained with nothing new
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      out_valid_reg <= 1'b0;
      data_x_reg    <= '0;
      data_y_reg    <= '0;
      mask_x_reg    <= 1'b0;
      mask_y_reg    <= 1'b0;
      out_src_reg   <= 1'b0;
    end else if (load) begin
      out_valid_reg <= addq_xfer || gpu_xfer;
      if (addq_xfer) begin
        data_x_reg  <= bus.addq_x;
        data_y_reg  <= bus.addq_y;
        mask_x_reg  <= 1'b1;
        mask_y_reg  <= 1'b1;
        out_src_reg <= 1'b1;
      end else if (gpu_xfer) begin
        data_x_reg  <= gpu_half[0];
        data_y_reg  <= gpu_half[1];
        mask_x_reg  <= bus.gpu_en_lo;
        mask_y_reg  <= bus.gpu_en_hi;
        out_src_reg <= 1'b0;
      end
    end
  end

  assign bus.gpu_ready  = gpu_ready_int;
  assign bus.addq_ready = addq_ready_int;
  assign bus.out_valid  = out_valid_reg;
  assign bus.data_x     = data_x_reg;
  assign bus.data_y     = data_y_reg;
  assign bus.mask_x     = mask_x_reg;
  assign bus.mask_y     = mask_y_reg;
  assign bus.out_src    = out_src_reg;

endmodule
